eae_sequencer: RTL and testbench

//  Control sequencer for the EAE (Extended Arithmetic Element) AC/MQ shift-add datapath.
//  It accepts one decoded EAE operation from the CPU state machine and issues one

---
 rtl/eae_sequencer_pkg.sv | 29 ++
 rtl/eae_step_counter.sv | 37 +++
 rtl/eae_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_eae_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/eae_sequencer_pkg.sv
// Shared EAE definitions: operation codes, sequencer states and datapath defaults.
package eae_sequencer_pkg;

    localparam int unsigned EaeWord   = 12;
    localparam int unsigned EaeNmiMax = 23;

    typedef enum logic [2:0] {
        OpNop = 3'd0,
        OpMuy = 3'd1,
        OpDvi = 3'd2,
        OpNmi = 3'd3,
        OpShl = 3'd4,
        OpAsr = 3'd5,
        OpLsr = 3'd6,
        OpScl = 3'd7
    } eae_op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StRun    = 2'd2,
        StFinish = 2'd3
    } eae_state_e;

    function automatic logic is_shift_op(eae_op_e o);
        return (o == OpShl) || (o == OpAsr) || (o == OpLsr);
    endfunction

endpackage

// File: rtl/eae_step_counter.sv
// 5-bit EAE step counter (SC): synchronous clear, load, increment and decrement.
module eae_step_counter #(
    parameter int unsigned MAX = 23
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       load,
    input  logic [4:0] load_val,
    input  logic       inc,
    input  logic       dec,
    output logic [4:0] value,
    output logic       is_zero,
    output logic       is_max
);

    logic [4:0] value_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value_q <= '0;
        end else if (clr) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_val;
        end else if (inc) begin
            value_q <= value_q + 5'd1;
        end else if (dec) begin
            value_q <= value_q - 5'd1;
        end
    end

    assign value   = value_q;
    assign is_zero = (value_q == 5'd0);
    assign is_max  = (value_q == 5'(MAX));

endmodule

// File: rtl/eae_sequencer.sv
// EAE control sequencer: accepts one decoded operation and issues one registered
// datapath strobe per clock while stepping SC, then pulses done.
module eae_sequencer
    import eae_sequencer_pkg::*;
#(
    parameter int unsigned WORD    = EaeWord,
    parameter int unsigned NMI_MAX = EaeNmiMax
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [4:0] count,
    input  logic       div_ovf,
    input  logic       norm_stop,
    output logic       busy,
    output logic       done,
    output logic [4:0] sc,
    output logic       sh_left,
    output logic       sh_rarith,
    output logic       sh_rlog,
    output logic       mul_step,
    output logic       div_step,
    output logic       set_link,
    output logic       clr_link
);

    localparam logic [4:0] WordM1 = 5'(WORD - 1);

    eae_state_e state_q, state_d;
    eae_op_e    op_q, op_in;
    logic [4:0] count_q;
    logic       ovf_q;
    logic       capture;

    logic       cnt_clr, cnt_load, cnt_inc, cnt_dec, cnt_zero, cnt_max;
    logic [4:0] cnt_val;
    logic       nmi_shift;
    logic       run_d;

    logic busy_d, done_d, sh_left_d, sh_rarith_d, sh_rlog_d;
    logic mul_step_d, div_step_d, set_link_d, clr_link_d;

    assign op_in = eae_op_e'(op);

    eae_step_counter #(
        .MAX(NMI_MAX)
    ) u_sc (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (cnt_clr),
        .load    (cnt_load),
        .load_val(cnt_val),
        .inc     (cnt_inc),
        .dec     (cnt_dec),
        .value   (sc),
        .is_zero (cnt_zero),
        .is_max  (cnt_max)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            op_q    <= OpNop;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                op_q    <= op_in;
                count_q <= count;
                ovf_q   <= div_ovf;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_inc    = 1'b0;
        cnt_dec    = 1'b0;
        nmi_shift  = 1'b0;
        set_link_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StSetup;
                    capture    = 1'b1;
                    // Overflowing divide is flagged while the operands are still valid.
                    set_link_d = (op_in == OpDvi) && div_ovf;
                end
            end
            StSetup: begin
                state_d = StFinish;
                if (is_shift_op(op_q)) begin
                    state_d  = StRun;
                    cnt_load = 1'b1;
                    cnt_val  = count_q;
                end else if (op_q == OpMuy || (op_q == OpDvi && !ovf_q)) begin
                    state_d  = StRun;
                    cnt_load = 1'b1;
                    cnt_val  = WordM1;
                end else if (op_q == OpNmi) begin
                    state_d  = StRun;
                    cnt_load = 1'b1;
                    cnt_val  = '0;
                end else if (op_q == OpScl) begin
                    cnt_load = 1'b1;
                    cnt_val  = count_q;
                end
            end
            StRun: begin
                if (op_q == OpNmi) begin
                    if (norm_stop || cnt_max) begin
                        state_d = StFinish;
                    end else begin
                        cnt_inc   = 1'b1;
                        nmi_shift = 1'b1;
                    end
                end else if (cnt_zero) begin
                    state_d = StFinish;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (clear) begin
            state_d    = StIdle;
            capture    = 1'b0;
            cnt_clr    = 1'b1;
            nmi_shift  = 1'b0;
            set_link_d = 1'b0;
        end
    end

    // Strobes are decoded from the next state so they line up with the RUN cycles.
    always_comb begin
        run_d       = (state_d == StRun);
        sh_left_d   = (run_d && op_q == OpShl) || nmi_shift;
        sh_rarith_d = run_d && (op_q == OpAsr);
        sh_rlog_d   = run_d && (op_q == OpLsr);
        mul_step_d  = run_d && (op_q == OpMuy);
        div_step_d  = run_d && (op_q == OpDvi);
        clr_link_d  = (state_d == StFinish) && (state_q == StRun) && (op_q == OpDvi);
        done_d      = (state_d == StFinish);
        busy_d      = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            sh_left   <= 1'b0;
            sh_rarith <= 1'b0;
            sh_rlog   <= 1'b0;
            mul_step  <= 1'b0;
            div_step  <= 1'b0;
            set_link  <= 1'b0;
            clr_link  <= 1'b0;
        end else begin
            busy      <= busy_d;
            done      <= done_d;
            sh_left   <= sh_left_d;
            sh_rarith <= sh_rarith_d;
            sh_rlog   <= sh_rlog_d;
            mul_step  <= mul_step_d;
            div_step  <= div_step_d;
            set_link  <= set_link_d;
            clr_link  <= clr_link_d;
        end
    end

endmodule

// File: tb/tb_eae_sequencer.sv
// Self-checking bench for eae_sequencer: directed scenarios plus random operations
// compared against a per-operation behavioural expectation.
module tb_eae_sequencer;

    localparam int unsigned WORD    = 12;
    localparam int unsigned NMI_MAX = 23;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [4:0] count = 5'd0;
    logic       div_ovf = 1'b0;
    logic       norm_stop = 1'b0;
    logic       busy, done, sh_left, sh_rarith, sh_rlog, mul_step, div_step, set_link, clr_link;
    logic [4:0] sc;
    logic [6:0] strb;

    int vectors = 0;
    int fails = 0;

    assign strb = {clr_link, set_link, div_step, mul_step, sh_rlog, sh_rarith, sh_left};

    eae_sequencer #(
        .WORD   (WORD),
        .NMI_MAX(NMI_MAX)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (clear),
        .start    (start),
        .op       (op),
        .count    (count),
        .div_ovf  (div_ovf),
        .norm_stop(norm_stop),
        .busy     (busy),
        .done     (done),
        .sc       (sc),
        .sh_left  (sh_left),
        .sh_rarith(sh_rarith),
        .sh_rlog  (sh_rlog),
        .mul_step (mul_step),
        .div_step (div_step),
        .set_link (set_link),
        .clr_link (clr_link)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one operation; cycle 1 is the first cycle after the edge that samples start.
    task automatic run_op(input int o, input int c, input int ovf, input int stop_after,
                          input int spurious);
        int    n[7];
        int    first[7];
        int    last[7];
        int    exp_n[7];
        int    exp_done, exp_sc, exp_first, main_idx, shifts;
        int    done_cnt, done_cyc, sc_done, multi, busy_bad, clr_wo_done;
        int    ones;
        string t;
        t = $sformatf("op%0d c%0d ovf%0d", o, c, ovf);
        for (int i = 0; i < 7; i++) begin
            n[i] = 0; first[i] = -1; last[i] = -1; exp_n[i] = 0;
        end
        exp_done = 2; exp_sc = -1; main_idx = -1; exp_first = 2;
        case (o)
            4, 5, 6: begin
                main_idx = o - 4; exp_n[main_idx] = c + 1; exp_done = c + 3; exp_sc = 0;
            end
            1: begin
                main_idx = 3; exp_n[3] = WORD; exp_done = WORD + 2; exp_sc = 0;
            end
            2: begin
                if (ovf != 0) begin
                    main_idx = 5; exp_n[5] = 1; exp_first = 1;
                end else begin
                    main_idx = 4; exp_n[4] = WORD; exp_n[6] = 1; exp_done = WORD + 2; exp_sc = 0;
                end
            end
            3: begin
                shifts = (stop_after < int'(NMI_MAX)) ? stop_after : int'(NMI_MAX);
                exp_n[0] = shifts; exp_sc = shifts; exp_done = -1;
            end
            7: exp_sc = c;
            default: ;
        endcase

        done_cnt = 0; done_cyc = -1; sc_done = -1; multi = 0; busy_bad = 0; clr_wo_done = 0;
        @(negedge clk);
        op = 3'(o); count = 5'(c); div_ovf = ovf[0]; start = 1'b1;
        norm_stop = (stop_after == 0);
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            ones = 0;
            for (int i = 0; i < 7; i++) begin
                if (strb[i]) begin
                    n[i]++;
                    ones++;
                    if (first[i] < 0) first[i] = cyc;
                    last[i] = cyc;
                end
            end
            if (ones > 1) multi++;
            if (clr_link && !done) clr_wo_done++;
            if (!done) begin
                if (done_cnt == 0 && busy !== 1'b1) busy_bad++;
                if (done_cnt > 0 && busy !== 1'b0) busy_bad++;
            end else begin
                if (done_cnt == 0) begin
                    done_cyc = cyc;
                    sc_done = int'(sc);
                end
                done_cnt++;
            end
            // Scramble the request inputs to show they were latched at start.
            op = 3'($urandom); count = 5'($urandom); div_ovf = 1'($urandom);
            start = (spurious > 0) && (cyc == spurious) && (exp_done >= 0) && (cyc <= exp_done);
            if (o == 3 && n[0] >= stop_after) norm_stop = 1'b1;
            if (done_cnt > 0 && cyc >= done_cyc + 2) break;
        end
        start = 1'b0;
        norm_stop = 1'b0;

        check({t, " done_seen"}, int'(done_cnt > 0), 1);
        check({t, " done_pulses"}, done_cnt, 1);
        if (exp_done >= 0) check({t, " done_cycle"}, done_cyc, exp_done);
        for (int i = 0; i < 7; i++) check($sformatf("%s strobe%0d_count", t, i), n[i], exp_n[i]);
        if (main_idx >= 0 && exp_n[main_idx] > 0 && o != 3) begin
            check({t, " first_strobe"}, first[main_idx], exp_first);
            check({t, " strobe_run"}, last[main_idx] - first[main_idx] + 1, exp_n[main_idx]);
        end
        if (exp_sc >= 0) check({t, " sc_at_done"}, sc_done, exp_sc);
        check({t, " one_hot"}, multi, 0);
        check({t, " busy"}, busy_bad, 0);
        check({t, " clr_link_with_done"}, clr_wo_done, 0);
    endtask

    initial begin
        int dc;
        int ro, rc, rv, rs, rp;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({busy, done, sc, strb}), 0);
        resetn = 1'b1;
        @(negedge clk);
        check("idle_outputs", int'({busy, done, sc, strb}), 0);

        run_op(4, 2, 0, 0, 0);       // SHL count=2
        run_op(1, 0, 0, 0, 0);       // MUY
        run_op(2, 0, 1, 0, 0);       // DVI overflow
        run_op(2, 0, 0, 0, 0);       // DVI normal
        run_op(3, 0, 0, 5, 0);       // NMI stop after 5
        run_op(3, 0, 0, 99, 0);      // NMI forced stop
        run_op(3, 0, 0, 0, 0);       // NMI already normalised
        run_op(1, 0, 0, 0, 6);       // start during busy MUY
        run_op(5, 0, 0, 0, 3);       // start on done cycle
        run_op(6, 31, 0, 0, 0);      // LSR maximum count
        run_op(0, 9, 0, 0, 1);       // NOP

        // clear at RUN cycle 4 of a MUY, together with a new start
        @(negedge clk);
        op = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("clear_pre_mul_step", int'(mul_step), 1);
        clear = 1'b1; start = 1'b1; op = 3'd4; count = 5'd3;
        @(negedge clk);
        clear = 1'b0; start = 1'b0;
        check("clear_busy", int'(busy), 0);
        check("clear_sc", int'(sc), 0);
        check("clear_strobes", int'(strb), 0);
        dc = int'(done) + int'(busy);
        repeat (16) begin
            @(negedge clk);
            dc += int'(done) + int'(busy);
        end
        check("clear_no_done", dc, 0);
        run_op(4, 3, 0, 0, 0);

        // async reset in the middle of an ASR
        @(negedge clk);
        op = 3'd5; count = 5'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_rarith", int'(sh_rarith), 1);
        #2 resetn = 1'b0;
        #1 check("async_reset_outputs", int'({busy, done, sc, strb}), 0);
        @(negedge clk);
        resetn = 1'b1;
        dc = 0;
        repeat (4) begin
            @(negedge clk);
            dc += int'(done) + int'(busy);
        end
        check("post_reset_idle", dc, 0);
        run_op(7, 17, 0, 0, 0);      // SCL count=17

        // random operations
        for (int k = 0; k < 40; k++) begin
            ro = int'($urandom_range(0, 7));
            rc = int'($urandom_range(0, 31));
            rv = int'($urandom_range(0, 1));
            rs = int'($urandom_range(0, 30));
            rp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : 0;
            run_op(ro, rc, rv, rs, rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
